exe_mult_div_unit: RTL and testbench
====================================

Name: exe_mult_div_unit

Overview:
- Iterative multiply/divide engine in the EXE stage. It consumes the operands and control fields latched by the ID/EXE pipeline register and produces the HI/LO result pair.
- Signed and unsigned 32x32 multiply and divide, computed one bit per cycle.
- While a multiply or divide is in flight, o_stall holds the ID/EXE register (its enable = ~o_stall) and freezes the upstream stages.
- On completion it pulses o_done with the result, so the EXE->MEM path can write HI/LO.

Parameters:
WIDTH, 32, operand width; product/dividend datapath is 2*WIDTH internally
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
i_start  in  1  EXE holds a mult/div instruction (decoded RegHi_we & RegLo_we from ID/EXE)
i_is_div  in  1  1 = divide, 0 = multiply
i_is_unsigned  in  1  1 = unsigned operation
i_opr1  in  WIDTH  multiplicand / dividend (rs)
i_opr2  in  WIDTH  multiplier / divisor (rt)
i_cancel  in  1  flush from exception/ERET in a later stage
o_stall  out  1  hold ID/EXE and upstream stages
o_done  out  1  one-cycle result-valid pulse
o_hi  out  WIDTH  product high word / remainder
o_lo  out  WIDTH  product low word / quotient
o_div_by_zero  out  1  valid with o_done; divisor was zero

Behaviour:
- FSM states: IDLE, CALC, SIGN, DONE.
- Reset: state = IDLE; counter = 0; o_hi = o_lo = 0; o_done = 0; o_div_by_zero = 0; o_stall = 0.
- IDLE & i_start & ~i_cancel (cycle T0), the start cycle:
  - Latch operand magnitudes. When signed, each negative operand is 2's-complemented.
  - Latch the result sign flags and op type; clear counter; go to CALC.
- Divide-by-zero at T0 (i_is_div & i_opr2 == 0):
  - Skip CALC/SIGN and go straight to DONE.
  - Result: o_hi = i_opr1, o_lo = all-ones, o_div_by_zero = 1.
- CALC, one iteration per cycle, WIDTH cycles (T1..T32):
  - Multiply: shift-add. If multiplier LSB is set, add the multiplicand into the upper half of the 2*WIDTH accumulator, then shift right 1.
  - Divide: restoring. Shift the {rem, quo} pair left 1; trial subtract the divisor from rem; if non-negative, keep the difference and set quo LSB.
  - After counter == WIDTH-1, go to SIGN.
- SIGN (T33):
  - Multiply: negate the 64-bit product if the signs differ (signed only).
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Register the final o_hi/o_lo; go to DONE.
- DONE (T34):
  - o_done = 1, o_stall = 0; the pipeline advances; next state IDLE.
  - i_start is ignored in DONE because it still reflects the departing instruction.
- o_stall is combinational: (IDLE & i_start & ~i_cancel) | CALC | SIGN.
  - Normal op: stall high T0..T33 (34 cycles); done at T34; total latency 34 cycles of stall.
  - Divide-by-zero: stall high T0 only; done at T1.
- o_hi/o_lo change only on entry to DONE. They hold their value otherwise, including across IDLE and later stalls.
- o_done and o_div_by_zero are high only in DONE. o_div_by_zero is 0 for multiplies.
- i_cancel in any state:
  - Next state IDLE, no o_done, o_hi/o_lo unchanged.
  - o_stall drops in the same cycle (combinational term gated by ~i_cancel).
  - i_cancel has priority over i_start.
- Signed corner cases:
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (magnitude arithmetic wraps naturally).
  - 0x80000000 * 0x80000000: {hi,lo} = 0x40000000_00000000.
- Unsigned ops never negate.
- Reset asserted mid-op: the reset values are taken next edge; no done pulse.

Test Plan:
- Unsigned divide 100/7, i_start held → stall high for 34 cycles; o_done at T34 with lo=0x0000000E, hi=0x00000002, div_by_zero=0.
- Signed divide 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- Signed multiply -3 * 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned multiply 0xFFFFFFFF * 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Divide 5/0 → stall high only at T0; o_done at T1 with hi=5, lo=0xFFFFFFFF, div_by_zero=1.
- Cancel: start signed multiply, assert i_cancel at T10 → stall low at T10, IDLE at T11, no o_done, hi/lo keep the previous result.
- Reset: resetn high at T5 of a divide → next cycle o_stall=0, o_hi=o_lo=0; a fresh start then completes normally.

Source files
------------

// File: rtl/exe_mult_div_unit.sv
// Iterative 32x32 signed/unsigned multiply (shift-add) and divide (restoring) for the EXE stage.
// Holds the ID/EXE register via o_stall while busy and pulses o_done with the HI/LO result.
module exe_mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_is_unsigned,
    input  logic [WIDTH-1:0] i_opr1,
    input  logic [WIDTH-1:0] i_opr2,
    input  logic             i_cancel,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);
    // state | meaning
    // IDLE  | waiting for a mult/div in EXE
    // CALC  | one shift-add / restoring-subtract step per cycle
    // SIGN  | apply result signs, register HI/LO
    // DONE  | result valid, pipeline released
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_start;
    logic               w_dbz_start;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_start     = (r_state == S_IDLE) & i_start & ~i_cancel;
    assign w_dbz_start = w_start & i_is_div & (i_opr2 == '0);
    assign w_neg_a     = ~i_is_unsigned & i_opr1[WIDTH-1];
    assign w_neg_b     = ~i_is_unsigned & i_opr2[WIDTH-1];
    assign w_mag_a     = w_neg_a ? (~i_opr1 + 1'b1) : i_opr1;
    assign w_mag_b     = w_neg_b ? (~i_opr2 + 1'b1) : i_opr2;

    // Multiply: multiplier sits in the low half and is consumed from the LSB.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: shifted remainder needs one extra bit; a successful difference always fits WIDTH.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_prod_fix = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = w_dbz_start ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_SIGN;
            S_SIGN: w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_cancel) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt     <= '0;
                r_is_div  <= i_is_div;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
                r_dbz     <= w_dbz_start;
                r_acc     <= {{WIDTH{1'b0}}, (i_is_div ? w_mag_a : w_mag_b)};
                r_opb     <= i_is_div ? w_mag_b : w_mag_a;
                if (w_dbz_start) begin
                    r_hi <= i_opr1;
                    r_lo <= '1;
                end
            end
            if (r_state == S_CALC && !i_cancel) begin
                r_acc <= r_is_div ? w_div_next : w_mul_next;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_SIGN && !i_cancel) begin
                r_hi <= r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
            end
        end
    end

    assign o_stall       = ~i_cancel & (w_start | (r_state == S_CALC) | (r_state == S_SIGN));
    assign o_done        = (r_state == S_DONE);
    assign o_div_by_zero = (r_state == S_DONE) & r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_exe_mult_div_unit.sv
// Directed-vector bench for exe_mult_div_unit: result values, stall latency, cancel and reset.
module tb_exe_mult_div_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        i_start, i_is_div, i_is_unsigned, i_cancel;
    logic [31:0] i_opr1, i_opr2;
    logic        o_stall, o_done, o_div_by_zero;
    logic [31:0] o_hi, o_lo;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        div;
        logic        uns;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_stall;
    } vec_t;

    vec_t vecs[12];

    exe_mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_is_div(i_is_div),
        .i_is_unsigned(i_is_unsigned), .i_opr1(i_opr1), .i_opr2(i_opr2),
        .i_cancel(i_cancel), .o_stall(o_stall), .o_done(o_done), .o_hi(o_hi),
        .o_lo(o_lo), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int  n_stall;
        bit  seen;
        next_cyc();
        i_start = 1'b1; i_is_div = v.div; i_is_unsigned = v.uns;
        i_opr1 = v.a; i_opr2 = v.b;
        #1;
        n_stall = 0;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (o_done) begin
                seen = 1;
                i_start = 1'b0;
                chk($sformatf("v%0d hi", idx), o_hi, v.exp_hi);
                chk($sformatf("v%0d lo", idx), o_lo, v.exp_lo);
                chk($sformatf("v%0d dbz", idx), {31'b0, o_div_by_zero}, {31'b0, v.exp_dbz});
                chk($sformatf("v%0d stall_cycles", idx), n_stall, v.exp_stall);
                chk($sformatf("v%0d stall_at_done", idx), {31'b0, o_stall}, 32'd0);
            end else begin
                if (o_stall) n_stall++;
                next_cyc();
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL v%0d timeout: no done after 60 cycles, stall count %0d", idx, n_stall);
            i_start = 1'b0;
        end
        next_cyc();
        chk($sformatf("v%0d done_pulse", idx), {31'b0, o_done}, 32'd0);
        chk($sformatf("v%0d hold_hi", idx), o_hi, v.exp_hi);
    endtask

    initial begin
        vecs[0]  = '{32'd100,      32'd7,        1, 1, 32'h00000002, 32'h0000000E, 0, 34};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h00000000, 32'h80000000, 0, 34};
        vecs[3]  = '{32'hFFFFFFFD, 32'd5,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFE, 32'h00000001, 0, 34};
        vecs[5]  = '{32'd5,        32'd0,        1, 1, 32'h00000005, 32'hFFFFFFFF, 1, 1};
        vecs[6]  = '{32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h00000000, 0, 34};
        vecs[7]  = '{32'hFFFFFFF9, 32'd2,        1, 1, 32'h00000001, 32'h7FFFFFFC, 0, 34};
        vecs[8]  = '{32'd7,        32'hFFFFFFFE, 1, 0, 32'h00000001, 32'hFFFFFFFD, 0, 34};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h00000001, 0, 34};
        vecs[10] = '{32'hFFFFFFF9, 32'd0,        1, 0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1};
        vecs[11] = '{32'h12345678, 32'h00000010, 0, 1, 32'h00000001, 32'h23456780, 0, 34};

        resetn = 1'b1; i_start = 1'b0; i_is_div = 1'b0; i_is_unsigned = 1'b0;
        i_cancel = 1'b0; i_opr1 = '0; i_opr2 = '0;
        next_cyc();
        next_cyc();
        resetn = 1'b0;
        #1;
        chk("reset stall", {31'b0, o_stall}, 32'd0);
        chk("reset done", {31'b0, o_done}, 32'd0);
        chk("reset dbz", {31'b0, o_div_by_zero}, 32'd0);
        chk("reset hi", o_hi, 32'd0);
        chk("reset lo", o_lo, 32'd0);

        for (int i = 0; i < 12; i++) run_op(i, vecs[i]);

        // Cancel a signed multiply at T10; previous result (vector 11) must survive.
        next_cyc();
        i_start = 1'b1; i_is_div = 1'b0; i_is_unsigned = 1'b0;
        i_opr1 = 32'hFFFFFFFD; i_opr2 = 32'd5;
        #1;
        chk("cancel stall_T0", {31'b0, o_stall}, 32'd1);
        for (int c = 0; c < 10; c++) next_cyc();
        chk("cancel stall_T10_pre", {31'b0, o_stall}, 32'd1);
        i_cancel = 1'b1;
        #1;
        chk("cancel stall_T10", {31'b0, o_stall}, 32'd0);
        next_cyc();
        i_cancel = 1'b0; i_start = 1'b0;
        #1;
        chk("cancel stall_T11", {31'b0, o_stall}, 32'd0);
        begin
            int n_done = 0;
            for (int c = 0; c < 40; c++) begin
                if (o_done) n_done++;
                next_cyc();
            end
            chk("cancel no_done", n_done, 32'd0);
        end
        chk("cancel hi_kept", o_hi, 32'h00000001);
        chk("cancel lo_kept", o_lo, 32'h23456780);

        // Reset at T5 of a divide, then a fresh start completes normally.
        next_cyc();
        i_start = 1'b1; i_is_div = 1'b1; i_is_unsigned = 1'b1;
        i_opr1 = 32'd100; i_opr2 = 32'd7;
        for (int c = 0; c < 5; c++) next_cyc();
        resetn = 1'b1; i_start = 1'b0;
        next_cyc();
        resetn = 1'b0;
        #1;
        chk("midreset stall", {31'b0, o_stall}, 32'd0);
        chk("midreset done", {31'b0, o_done}, 32'd0);
        chk("midreset hi", o_hi, 32'd0);
        chk("midreset lo", o_lo, 32'd0);
        run_op(100, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
